uart_debugger: RTL and testbench
================================

# uart_debugger

Debug-output block that takes a parallel data word on a valid strobe and prints it over a UART TX line as uppercase ASCII hexadecimal followed by CR LF. It lets a terminal observe internal buses without a host interface. It sits at the edge of the design and drives one TX pin. Single clock domain, fixed 8N1 framing.

## Interface
Parameters:
- DATA_BYTES, default 1: width of i_data in bytes (≥1); message is 2·DATA_BYTES hex characters.
- CLK_RATE_HZ, default 50_000_000: i_clk frequency.
- BAUD_RATE, default 115_200: UART bit rate.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  reset. One clock; reset is synchronous and active-high.
- i_data_valid  in  1  request to print i_data; level-sensitive, sampled only when idle.
- i_data  in  8·DATA_BYTES  word to print, captured on acceptance.
- o_uart_tx  out  1  UART serial output; idle high.

## Operation
- Derived constant CLKS_PER_BIT = CLK_RATE_HZ / BAUD_RATE, integer division, truncated (50 MHz / 115200 = 434).
- States: IDLE, SEND (character in flight), NEXT (select next character).
- IDLE: o_uart_tx = 1. When i_data_valid = 1, latch i_data into a shadow register, set the character index to 0, and go to SEND.
- Character sequence: nibbles of the latched word, most significant nibble first. 0–9 map to 0x30–0x39; 10–15 map to 0x41–0x46 (uppercase). After the last nibble, send 0x0D then 0x0A.
- Each character is sent 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
- After the stop bit of 0x0A, return to IDLE.
- i_data_valid and i_data are ignored while not in IDLE. Requests made during a message are dropped, not queued.
- If i_data_valid is held high continuously, messages repeat back-to-back, each with freshly captured data.
- Reset: all state returns to IDLE and o_uart_tx = 1 on the next edge. This aborts any frame in progress, mid-bit or mid-message. Nothing resumes after reset.

## Timing
- Acceptance edge: the edge where IDLE and i_data_valid = 1. The start bit appears on o_uart_tx on the following cycle.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- No gap between characters: the next start bit immediately follows the previous stop bit.
- The message occupies (2·DATA_BYTES + 2) · 10 · CLKS_PER_BIT cycles.
- After the final stop bit there is exactly one IDLE cycle with o_uart_tx = 1 before the next acceptance.
- o_uart_tx is driven from a register (glitch-free).

## Structure
- Sub-module uart_byte_tx: 8N1 serializer. Ports: i_clk, i_reset, i_start, i_byte[7:0], o_tx, o_done. Parameter CLKS_PER_BIT. o_done pulses one cycle at the end of the stop bit.
- Top level holds the sequencer: shadow register, character index of width clog2(2·DATA_BYTES+2), nibble-to-ASCII mux.
- Shared package uart_debug_pkg holds:
  - constants ASCII_CR = 8'h0D and ASCII_LF = 8'h0A;
  - function hex_to_ascii(4-bit) returning 8-bit;
  - the state enum.

## Test plan
- DATA_BYTES=1, CLK 50 MHz, i_data=0xCF, valid pulsed one cycle -> bytes 0x43, 0x46, 0x0D, 0x0A decoded; each bit 434 cycles wide; line high afterwards.
- DATA_BYTES=2, i_data=0x30F0 -> bytes 0x33, 0x30, 0x46, 0x30, 0x0D, 0x0A; total 60·434 cycles from start bit to end of last stop bit.
- Valid held high continuously with a changing i_data -> repeated messages, each reflecting the value at its acceptance edge, separated by exactly one idle cycle.
- Second valid pulse during an in-flight message with a different value -> ignored; only the first message is emitted.
- Reset asserted mid-character -> o_uart_tx = 1 the next cycle and stays high; a new valid after reset is sent cleanly from the start bit.
- i_data=0x0A (DATA_BYTES=1) -> "0A" encoded as 0x30, 0x41 (uppercase check), then 0x0D, 0x0A.

Source files
------------

// File: rtl/uart_debug_pkg.sv
// Shared definitions for the UART hex debug printer: ASCII constants,
// the sequencer state encoding and the nibble-to-ASCII conversion.
package uart_debug_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // IDLE: line idle, waiting for a request
    // SEND: a character is on the wire
    // NEXT: first cycle after the next character has been launched
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        NEXT
    } state_t;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' (uppercase)
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        logic [7:0] ch;
        if (nibble < 4'd10) begin
            ch = 8'h30 + {4'h0, nibble};
        end else begin
            ch = 8'h37 + {4'h0, nibble};
        end
        return ch;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 serializer: start bit, 8 data bits LSB first, one stop bit.
// A new byte may be loaded in the last cycle of the stop bit (when o_done
// is high) so consecutive characters leave no gap on the line.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_done
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      STOP_IDX = 4'd9;

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       frame;
    logic             tx;
    logic             bit_end;
    logic             load;

    assign bit_end = (cnt == CNT_LAST);
    assign o_done  = busy && bit_end && (bit_idx == STOP_IDX);
    assign load    = i_start && (!busy || o_done);
    assign o_tx    = tx;

    // Bit timing and line driver; reset aborts any frame and idles the line
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else if (load) begin
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
        end else if (busy) begin
            if (bit_end) begin
                cnt <= '0;
                if (bit_idx == STOP_IDX) begin
                    busy <= 1'b0;
                    tx   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= frame[0];
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Remaining bits to shift out: data LSB first, then the stop bit
    always_ff @(posedge i_clk) begin
        if (load) begin
            frame <= {1'b1, i_byte};
        end else if (busy && bit_end && (bit_idx != STOP_IDX)) begin
            frame <= {1'b1, frame[8:1]};
        end
    end

endmodule

// File: rtl/uart_debugger.sv
// Prints a captured data word over UART as uppercase hex followed by CR LF.
// The first character is launched on the acceptance edge, and each following
// character is launched on the edge that ends the previous stop bit.
module uart_debugger #(
    parameter int DATA_BYTES  = 1,
    parameter int CLK_RATE_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_data_valid,
    input  logic [8*DATA_BYTES-1:0] i_data,
    output logic                    o_uart_tx
);

    import uart_debug_pkg::*;

    localparam int CLKS_PER_BIT = CLK_RATE_HZ / BAUD_RATE;
    localparam int DATA_W       = 8 * DATA_BYTES;
    localparam int NIBBLES      = 2 * DATA_BYTES;
    localparam int NUM_CHARS    = NIBBLES + 2;
    localparam int IDX_W        = $clog2(NUM_CHARS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHARS - 1);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shadow;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              advance;
    logic              start;
    logic [7:0]        tx_byte;
    logic              done;

    // Character at position pos: hex nibbles MS first, then CR, then LF
    function automatic logic [7:0] char_at(input logic [DATA_W-1:0] word,
                                           input logic [IDX_W-1:0]  pos);
        logic [3:0] nibble;
        logic [7:0] ch;
        nibble = '0;
        ch     = ASCII_LF;
        if (int'(pos) < NIBBLES) begin
            nibble = 4'(word >> (4 * (NIBBLES - 1 - int'(pos))));
            ch     = hex_to_ascii(nibble);
        end else if (int'(pos) == NIBBLES) begin
            ch = ASCII_CR;
        end
        return ch;
    endfunction

    // Sequencer state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Character index: cleared on acceptance, stepped on each launch
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Shadow copy of the word being printed
    always_ff @(posedge i_clk) begin
        if (accept) begin
            shadow <= i_data;
        end
    end

    // Next state, character launch and character selection
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        advance    = 1'b0;
        start      = 1'b0;
        tx_byte    = '0;
        case (state)
            IDLE: begin
                if (i_data_valid) begin
                    accept     = 1'b1;
                    start      = 1'b1;
                    tx_byte    = char_at(i_data, '0);
                    state_next = SEND;
                end
            end
            SEND: begin
                if (done) begin
                    if (idx == IDX_LAST) begin
                        state_next = IDLE;
                    end else begin
                        advance    = 1'b1;
                        start      = 1'b1;
                        tx_byte    = char_at(shadow, idx + IDX_W'(1));
                        state_next = NEXT;
                    end
                end
            end
            NEXT: begin
                state_next = SEND;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_start(start),
        .i_byte (tx_byte),
        .o_tx   (o_uart_tx),
        .o_done (done)
    );

endmodule

// File: tb/tb_uart_debugger.sv
// Directed bench for uart_debugger: three instances (1-byte and 2-byte at
// 434 clocks per bit, 1-byte at 10 clocks per bit for the faster scenarios).
// Every line sample is compared against the frame built from the expected byte.
module tb_uart_debugger;

    logic        clk;
    logic        rst;
    logic        valid_a, valid_b, valid_c;
    logic [7:0]  data_a, data_c;
    logic [15:0] data_b;
    logic        tx_a, tx_b, tx_c;
    logic        tx_sel;
    int          sel;
    int          checks;
    int          errors;
    logic [7:0]  exp_bytes [0:5];

    uart_debugger #(.DATA_BYTES(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_data_valid(valid_a), .i_data(data_a), .o_uart_tx(tx_a)
    );

    uart_debugger #(.DATA_BYTES(2)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_data_valid(valid_b), .i_data(data_b), .o_uart_tx(tx_b)
    );

    uart_debugger #(.DATA_BYTES(1), .CLK_RATE_HZ(1_000_000), .BAUD_RATE(100_000)) dut_c (
        .i_clk(clk), .i_reset(rst), .i_data_valid(valid_c), .i_data(data_c), .o_uart_tx(tx_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (sel)
            0:       tx_sel = tx_a;
            1:       tx_sel = tx_b;
            default: tx_sel = tx_c;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Samples every cycle of n characters from the selected line, starting at
    // the current falling edge (first cycle of the first start bit). Optionally
    // pulses valid_c for one cycle at message cycle inj_at.
    task automatic recv_msg(input string tag, input int n, input int cpb,
                            input int inj_at, input logic [7:0] inj_data);
        int         cyc;
        int         bad;
        logic [9:0] frame;
        logic [7:0] got;
        cyc = 0;
        for (int c = 0; c < n; c++) begin
            frame = {1'b1, exp_bytes[c], 1'b0};
            got   = '0;
            bad   = 0;
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < cpb; k++) begin
                    if (tx_sel !== frame[b]) bad++;
                    if (k == cpb / 2 && b >= 1 && b <= 8) got[b-1] = tx_sel;
                    if (cyc == inj_at) begin
                        valid_c = 1'b1;
                        data_c  = inj_data;
                    end else if (cyc == inj_at + 1) begin
                        valid_c = 1'b0;
                    end
                    cyc++;
                    @(negedge clk);
                end
            end
            check($sformatf("%s char%0d byte", tag, c), {24'h0, got}, {24'h0, exp_bytes[c]});
            check($sformatf("%s char%0d bad_samples", tag, c), bad, 0);
        end
    endtask

    // Line must stay high for the given number of cycles
    task automatic quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_sel !== 1'b1) lows++;
            @(negedge clk);
        end
        check(tag, lows, 0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        sel     = 0;
        rst     = 1'b1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        valid_c = 1'b0;
        data_a  = '0;
        data_b  = '0;
        data_c  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx_a", {31'h0, tx_a}, 32'h1);
        check("reset tx_b", {31'h0, tx_b}, 32'h1);
        check("reset tx_c", {31'h0, tx_c}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("idle tx_a", {31'h0, tx_a}, 32'h1);

        // 1 byte, 0xCF, 434 clocks per bit, single-cycle valid
        sel     = 0;
        data_a  = 8'hCF;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        data_a  = 8'h00;
        exp_bytes = '{8'h43, 8'h46, 8'h0D, 8'h0A, 8'h00, 8'h00};
        recv_msg("cf", 4, 434, -10, 8'h00);
        quiet("cf after", 20);

        // 2 bytes, 0x30F0: 60 bit times from start bit to end of last stop bit
        sel     = 1;
        data_b  = 16'h30F0;
        valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        data_b  = 16'hFFFF;
        exp_bytes = '{8'h33, 8'h30, 8'h46, 8'h30, 8'h0D, 8'h0A};
        recv_msg("30f0", 6, 434, -10, 8'h00);
        quiet("30f0 after", 20);

        // Valid held high with changing data: back-to-back messages, one idle cycle
        sel     = 2;
        data_c  = 8'h5B;
        valid_c = 1'b1;
        @(negedge clk);
        data_c  = 8'h77;
        exp_bytes = '{8'h35, 8'h42, 8'h0D, 8'h0A, 8'h00, 8'h00};
        recv_msg("held1", 4, 10, -10, 8'h00);
        check("held gap high", {31'h0, tx_c}, 32'h1);
        data_c  = 8'hE4;
        @(negedge clk);
        valid_c = 1'b0;
        data_c  = 8'h11;
        exp_bytes = '{8'h45, 8'h34, 8'h0D, 8'h0A, 8'h00, 8'h00};
        recv_msg("held2", 4, 10, -10, 8'h00);
        quiet("held after", 30);

        // Second request during a message is dropped
        data_c  = 8'hA5;
        valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        exp_bytes = '{8'h41, 8'h35, 8'h0D, 8'h0A, 8'h00, 8'h00};
        recv_msg("overlap", 4, 10, 150, 8'h3C);
        quiet("overlap dropped", 60);

        // Reset mid-character aborts; a later request starts cleanly
        data_c  = 8'h00;
        valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        repeat (24) @(negedge clk);
        check("pre-reset low", {31'h0, tx_c}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("reset abort high", {31'h0, tx_c}, 32'h1);
        rst = 1'b0;
        quiet("post-reset quiet", 60);

        // 0x0A: uppercase hex letter, sent cleanly after the aborted frame
        data_c  = 8'h0A;
        valid_c = 1'b1;
        @(negedge clk);
        valid_c = 1'b0;
        exp_bytes = '{8'h30, 8'h41, 8'h0D, 8'h0A, 8'h00, 8'h00};
        recv_msg("0a", 4, 10, -10, 8'h00);
        quiet("0a after", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
